controle_multiplicador: RTL
===========================

# controle_multiplicador

Sequential shift-and-add controller for the 8×8 unsigned multiplier. On a start request it captures both operands and computes the product over 8 iteration cycles. On every cycle it drives a 3-bit route code plus a 16-bit data word into the downstream 1-to-5 destination router, so the router's five outputs end up holding multiplicand, multiplier, running accumulator, final product and status. The router holds each output while its code is not selected, so this block is the only writer and fully sequences it.

## Interface
Parameters:
- N, 8, operand width; data word and product width are 2N (16, fixed by the router bus).

Ports:
- clock  in  1  single system clock, all state updates on rising edge
- reset_n  in  1  synchronous, active-low reset
- iniciar  in  1  start request, sampled only in OCIOSO
- operando_a  in  N  multiplicand, captured on accepted start
- operando_b  in  N  multiplier, captured on accepted start
- op  out  3  router destination code: 000 a, 001 b, 010 c, 011 d, 100 e, 111 none
- dado  out  2N  data word routed to the selected destination
- ocupado  out  1  high in every state except OCIOSO
- pronto  out  1  one-cycle completion pulse

## Operation
- All outputs registered (Moore), decoded from state and datapath registers.
- Reset values: op=111, dado=0, ocupado=0, pronto=0, accumulator=0, counter=0, state OCIOSO.
- States and outputs:
  - OCIOSO: op=111. Leaves to CARGA_A when iniciar=1. Operands are latched on that edge.
  - CARGA_A: op=000, dado={0,A}. Goes to CARGA_B.
  - CARGA_B: op=001, dado={0,B}. Goes to ITERA. Accumulator=0, i=0.
  - ITERA: each cycle, if B[i]=1 then acc += A<<i. op=010, dado=updated acc. i increments. After i=N-1, goes to RESULTADO.
  - RESULTADO: op=011, dado=acc. Goes to STATUS.
  - STATUS: op=100, dado={11'b0, zero, popcount(B)[3:0]}, where zero=(acc==0). Goes to FIM.
  - FIM: op=111, pronto=1. Goes to OCIOSO.
- Arithmetic is unsigned, 2N-bit. The maximum 255×255=0xFE01 fits, so overflow never occurs.
- iniciar while ocupado=1 is ignored, with no queuing. Operand input changes after capture have no effect.
- iniciar held high continuously restarts the sequence immediately after FIM, using the values present at that OCIOSO edge.
- op=111 outside the routing states guarantees the router keeps its previous values.

## Timing
- iniciar seen high at edge k: ocupado=1 and op=000 from edge k.
  - op=001 from edge k+1.
  - ITERA i=0..7 at edges k+2..k+9.
  - RESULTADO at k+10, STATUS at k+11, FIM (pronto=1) at k+12.
  - OCIOSO at k+13.
- Latency is 12 cycles from the accepting edge to pronto. Next start is accepted at edge k+13 at the earliest.
- Exactly one route code per cycle. Each destination is written exactly once per operation, except c, which is written N times.
- reset_n low at any edge, including mid-ITERA: all reset values apply at that edge. No partial router write follows, and pronto is not emitted.
- reset_n and iniciar both high-active in the same edge: reset wins.

## Structure
- Shared package `multiplicador_pkg` holds:
  - route codes: OP_A=000, OP_B=001, OP_C=010, OP_D=011, OP_E=100, OP_NENHUM=111;
  - state encoding;
  - status bit positions.
- Sub-module `fluxo_multiplicador` holds the operand registers, accumulator, iteration counter, popcount and zero flag. It is controlled by load/clear/step enables.
- This block holds the FSM and the output mux.

## Test plan
- A=13, B=11: c sequence 13, 39, 39, 143, 143, 143, 143, 143. d=0x008F, e=0x0003, pronto at k+12.
- A=0, B=200: c stays 0. d=0x0000, e=0x0013 (zero=1, popcount=3).
- A=255, B=255: d=0xFE01, e=0x0008. No overflow.
- iniciar pulsed at k+5 during an operation: ignored, result unchanged. iniciar held high: a second operation starts at k+13 with new operands, and pronto pulses at k+12 and k+25.
- reset_n low at k+6 (mid-ITERA): next cycle op=111, dado=0, ocupado=0. No pronto. A new start afterwards produces a correct 7×9 → d=0x003F.
- Idle for 20 cycles after reset: op stays 111, pronto stays 0, router outputs unchanged.

Source files
------------

// File: rtl/multiplicador_pkg.sv
// Shared encodings for the shift-and-add multiplier controller.
// Holds the router destination codes, the FSM states and the status word layout.
package multiplicador_pkg;

  typedef enum logic [2:0] {
    OP_A      = 3'b000,
    OP_B      = 3'b001,
    OP_C      = 3'b010,
    OP_D      = 3'b011,
    OP_E      = 3'b100,
    OP_NENHUM = 3'b111
  } rota_e;

  typedef enum logic [2:0] {
    OCIOSO    = 3'd0,
    CARGA_A   = 3'd1,
    CARGA_B   = 3'd2,
    ITERA     = 3'd3,
    RESULTADO = 3'd4,
    STATUS    = 3'd5,
    FIM       = 3'd6
  } estado_e;

  // Status word: popcount of the multiplier in the low nibble, zero flag above it
  localparam int ST_POP_LSB = 0;
  localparam int ST_POP_W   = 4;
  localparam int ST_ZERO    = 4;

endpackage

// File: rtl/fluxo_multiplicador.sv
// Datapath of the multiplier: operand registers, accumulator, iteration counter,
// plus the popcount and zero flag consumed by the status word.
module fluxo_multiplicador
  import multiplicador_pkg::*;
#(
  parameter int N  = 8,
  parameter int CW = $clog2(N + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             carga_i,
  input  logic             limpa_i,
  input  logic             passo_i,
  input  logic [N-1:0]     a_i,
  input  logic [N-1:0]     b_i,
  output logic [N-1:0]     b_o,
  output logic [2*N-1:0]   acc_o,
  output logic [2*N-1:0]   acc_passo_o,
  output logic             fim_o,
  output logic             zero_o,
  output logic [CW-1:0]    pop_o
);

  localparam int IW = $clog2(N);

  logic [N-1:0]   a_q, b_q;
  logic [2*N-1:0] acc_q, acc_d, parcela;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]  pop;

  // Partial product for the current bit; acc_d is what the accumulator becomes on a step
  always_comb begin
    parcela = b_q[cnt_q[IW-1:0]] ? ({{N{1'b0}}, a_q} << cnt_q) : '0;
    acc_d   = acc_q + parcela;
    cnt_d   = cnt_q + CW'(1);
  end

  always_comb begin
    pop = '0;
    for (int j = 0; j < N; j++) pop = pop + CW'(b_q[j]);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      if (carga_i) begin
        a_q <= a_i;
        b_q <= b_i;
      end
      if (limpa_i) begin
        acc_q <= '0;
        cnt_q <= '0;
      end else if (passo_i) begin
        acc_q <= acc_d;
        cnt_q <= cnt_d;
      end
    end
  end

  assign b_o         = b_q;
  assign acc_o       = acc_q;
  assign acc_passo_o = acc_d;
  assign fim_o       = (cnt_q == CW'(N));
  assign zero_o      = (acc_q == '0);
  assign pop_o       = pop;

endmodule

// File: rtl/controle_multiplicador.sv
// Sequencer for the 8x8 shift-and-add multiplier: drives one route code and data
// word per cycle into the 1-to-5 router, with all outputs registered.
module controle_multiplicador
  import multiplicador_pkg::*;
#(
  parameter int N = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             iniciar,
  input  logic [N-1:0]     operando_a,
  input  logic [N-1:0]     operando_b,
  output logic [2:0]       op,
  output logic [2*N-1:0]   dado,
  output logic             ocupado,
  output logic             pronto
);

  localparam int DW = 2 * N;
  localparam int CW = $clog2(N + 1);

  estado_e        estado_q;
  rota_e          op_q;
  logic [DW-1:0]  dado_q;
  logic           ocupado_q, pronto_q;

  logic           aceita, limpa, passo;
  logic [N-1:0]   b_w;
  logic [DW-1:0]  acc_w, acc_passo_w, status_w;
  logic           fim_w, zero_w;
  logic [CW-1:0]  pop_w;

  // FIM decides like OCIOSO so a held start restarts back-to-back
  assign aceita = ((estado_q == OCIOSO) || (estado_q == FIM)) && iniciar;
  assign limpa  = (estado_q == CARGA_A);
  assign passo  = (estado_q == CARGA_B) || ((estado_q == ITERA) && !fim_w);

  fluxo_multiplicador #(.N(N), .CW(CW)) u_fluxo (
    .clock       (clock),
    .reset_n     (reset_n),
    .carga_i     (aceita),
    .limpa_i     (limpa),
    .passo_i     (passo),
    .a_i         (operando_a),
    .b_i         (operando_b),
    .b_o         (b_w),
    .acc_o       (acc_w),
    .acc_passo_o (acc_passo_w),
    .fim_o       (fim_w),
    .zero_o      (zero_w),
    .pop_o       (pop_w)
  );

  always_comb begin
    status_w                         = '0;
    status_w[ST_ZERO]                = zero_w;
    status_w[ST_POP_LSB +: ST_POP_W] = ST_POP_W'(pop_w);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      estado_q  <= OCIOSO;
      op_q      <= OP_NENHUM;
      dado_q    <= '0;
      ocupado_q <= 1'b0;
      pronto_q  <= 1'b0;
    end else begin
      pronto_q  <= 1'b0;
      ocupado_q <= 1'b1;
      unique case (estado_q)
        OCIOSO, FIM: begin
          if (iniciar) begin
            estado_q <= CARGA_A;
            op_q     <= OP_A;
            dado_q   <= {{N{1'b0}}, operando_a};
          end else begin
            estado_q  <= OCIOSO;
            op_q      <= OP_NENHUM;
            ocupado_q <= 1'b0;
          end
        end
        CARGA_A: begin
          estado_q <= CARGA_B;
          op_q     <= OP_B;
          dado_q   <= {{N{1'b0}}, b_w};
        end
        CARGA_B: begin
          estado_q <= ITERA;
          op_q     <= OP_C;
          dado_q   <= acc_passo_w;
        end
        ITERA: begin
          if (!fim_w) begin
            op_q   <= OP_C;
            dado_q <= acc_passo_w;
          end else begin
            estado_q <= RESULTADO;
            op_q     <= OP_D;
            dado_q   <= acc_w;
          end
        end
        RESULTADO: begin
          estado_q <= STATUS;
          op_q     <= OP_E;
          dado_q   <= status_w;
        end
        STATUS: begin
          estado_q <= FIM;
          op_q     <= OP_NENHUM;
          pronto_q <= 1'b1;
        end
        default: begin
          estado_q  <= OCIOSO;
          op_q      <= OP_NENHUM;
          ocupado_q <= 1'b0;
        end
      endcase
    end
  end

  assign op      = op_q;
  assign dado    = dado_q;
  assign ocupado = ocupado_q;
  assign pronto  = pronto_q;

endmodule
